// File: rtl/custom_instr_pkg.sv
// Shared types and helpers for the custom-instruction dispatcher.
// The order-entry slot field is sized for the largest supported slot count (8).
package custom_instr_pkg;

    localparam int unsigned SLOT_IDX_W       = 3;
    localparam logic [31:0] UNMAPPED_DEFAULT = 32'hDEAD_C0DE;

    typedef struct packed {
        logic [SLOT_IDX_W-1:0] slot;
        logic                  unmapped;
    } order_entry_t;

    function automatic int unsigned sel_width(input int unsigned num_slots);
        return (num_slots <= 1) ? 1 : $clog2(num_slots);
    endfunction

endpackage

// File: rtl/ci_order_fifo.sv
// Order FIFO: remembers the source of every outstanding command, oldest at the head.
// The head entry is read combinationally. The occupancy count is registered.
module ci_order_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push  = push & (count_q != CNT_W'(DEPTH));
    assign do_pop   = pop & (count_q != '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/custom_instr_dispatch.sv
// Routes CPU custom-instruction commands to accelerator slots and returns their
// responses to the CPU strictly in command order. Unmapped slots answer with a fixed value.
module custom_instr_dispatch
    import custom_instr_pkg::*;
#(
    parameter int unsigned       NUM_SLOTS      = 4,
    parameter int unsigned       FID_W          = 10,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       ORDER_DEPTH    = 4,
    parameter logic [DATA_W-1:0] UNMAPPED_VALUE = DATA_W'(UNMAPPED_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [FID_W-1:0]              cmd_function_id,
    input  logic [DATA_W-1:0]             cmd_inputs_0,
    input  logic [DATA_W-1:0]             cmd_inputs_1,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_outputs_0,
    output logic [NUM_SLOTS-1:0]          slot_cmd_valid,
    input  logic [NUM_SLOTS-1:0]          slot_cmd_ready,
    output logic [FID_W-1:0]              slot_cmd_function_id,
    output logic [DATA_W-1:0]             slot_cmd_inputs_0,
    output logic [DATA_W-1:0]             slot_cmd_inputs_1,
    input  logic [NUM_SLOTS-1:0]          slot_rsp_valid,
    output logic [NUM_SLOTS-1:0]          slot_rsp_ready,
    input  logic [NUM_SLOTS*DATA_W-1:0]   slot_rsp_outputs_0,
    output logic [$clog2(ORDER_DEPTH):0]  outstanding,
    output logic [15:0]                   unmapped_count,
    output logic                          busy
);

    localparam int unsigned SEL_W = sel_width(NUM_SLOTS);
    localparam int unsigned CNT_W = $clog2(ORDER_DEPTH) + 1;

    logic [SEL_W-1:0]  cmd_idx;
    logic              cmd_unmapped;
    logic              accept;
    logic              cmd_xfer;
    logic              cmd_vld_q;
    logic [SEL_W-1:0]  cmd_slot_q;
    logic [FID_W-1:0]  cmd_fid_q;
    logic [DATA_W-1:0] cmd_in0_q, cmd_in1_q;
    logic [15:0]       unmapped_cnt_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              rsp_pop;
    order_entry_t      push_entry;
    order_entry_t      head_entry;

    assign cmd_idx      = cmd_function_id[FID_W-1 -: SEL_W];
    assign cmd_unmapped = (32'(cmd_idx) >= NUM_SLOTS);
    assign fifo_empty   = (fifo_count == '0);

    // Acceptance looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign cmd_ready = resetn & (fifo_count < CNT_W'(ORDER_DEPTH)) & (~cmd_vld_q | cmd_xfer);
    assign accept    = cmd_valid & cmd_ready;

    assign push_entry = '{slot: SLOT_IDX_W'(cmd_idx), unmapped: cmd_unmapped};

    always_comb begin
        slot_cmd_valid = '0;
        cmd_xfer       = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cmd_vld_q && (cmd_slot_q == SEL_W'(i))) begin
                slot_cmd_valid[i] = 1'b1;
                cmd_xfer          = slot_cmd_ready[i];
            end
        end
    end

    assign slot_cmd_function_id = cmd_fid_q;
    assign slot_cmd_inputs_0    = cmd_in0_q;
    assign slot_cmd_inputs_1    = cmd_in1_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_vld_q  <= 1'b0;
            cmd_slot_q <= '0;
            cmd_fid_q  <= '0;
            cmd_in0_q  <= '0;
            cmd_in1_q  <= '0;
        end else if (accept && !cmd_unmapped) begin
            cmd_vld_q  <= 1'b1;
            cmd_slot_q <= cmd_idx;
            cmd_fid_q  <= cmd_function_id;
            cmd_in0_q  <= cmd_inputs_0;
            cmd_in1_q  <= cmd_inputs_1;
        end else if (cmd_xfer) begin
            cmd_vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            unmapped_cnt_q <= '0;
        end else if (accept && cmd_unmapped && (unmapped_cnt_q != 16'hFFFF)) begin
            unmapped_cnt_q <= unmapped_cnt_q + 16'd1;
        end
    end

    ci_order_fifo #(
        .WIDTH ($bits(order_entry_t)),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_data (push_entry),
        .pop       (rsp_pop),
        .pop_data  (head_entry),
        .count     (fifo_count)
    );

    // The head entry alone decides which source may talk to the CPU.
    always_comb begin
        rsp_valid      = 1'b0;
        rsp_outputs_0  = '0;
        slot_rsp_ready = '0;
        if (!fifo_empty) begin
            if (head_entry.unmapped) begin
                rsp_valid     = 1'b1;
                rsp_outputs_0 = UNMAPPED_VALUE;
            end else begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (head_entry.slot == SLOT_IDX_W'(i)) begin
                        rsp_valid         = slot_rsp_valid[i];
                        rsp_outputs_0     = slot_rsp_outputs_0[i*DATA_W +: DATA_W];
                        slot_rsp_ready[i] = rsp_ready;
                    end
                end
            end
        end
    end

    assign rsp_pop        = rsp_valid & rsp_ready;
    assign outstanding    = fifo_count;
    assign unmapped_count = unmapped_cnt_q;
    assign busy           = ~fifo_empty | cmd_vld_q;

endmodule
